// File: rtl/biquad8_loader_pkg.sv
// Shared types and constants for the biquad pair coefficient loader.
package biquad8_loader_pkg;

  localparam int unsigned IDX_W     = 7;
  localparam int unsigned ADR_W     = 22;
  localparam int unsigned DAT_W     = 32;
  localparam int unsigned BQSEL_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    VERIFY,
    RSTQ,
    DONE,
    FAIL
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BUS     = 3'd1;
  localparam logic [2:0] ERR_RETRY   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;
  localparam logic [2:0] ERR_VERIFY  = 3'd5;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/biquad8_loader_stage_ram.sv
// Coefficient staging buffer: NWORDS x 32, synchronous write, combinational read.
module biquad8_loader_stage_ram
  import biquad8_loader_pkg::*;
#(
  parameter int unsigned NWORDS = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wadr,
  input  logic [DAT_W-1:0] wdat,
  input  logic [IDX_W-1:0] radr,
  output logic [DAT_W-1:0] rdat_c
);

  localparam int unsigned AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [DAT_W-1:0] mem [NWORDS];

  // Out-of-range indices must not alias onto a valid word.
  always_ff @(posedge clk) begin
    if (we && (32'(wadr) < NWORDS)) mem[AW'(wadr)] <= wdat;
  end

  assign rdat_c = mem[AW'(radr)];

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Wishbone sequencer bulk-loading staged coefficients into bq0/bq1, then pulsing the biquad reset.
// Optional write-then-read verify of every word under BIQUAD8_LOADER_READBACK_EN.
module biquad8_coeff_loader
  import biquad8_loader_pkg::*;
#(
  parameter int unsigned NWORDS     = 32,
  parameter int unsigned ADR_STEP   = 1,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RTY    = 3,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             stg_we_i,
  input  logic [IDX_W-1:0] stg_adr_i,
  input  logic [DAT_W-1:0] stg_dat_i,
  input  logic             start_i,
  input  logic [1:0]       target_i,
  input  logic             abort_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  input  logic [DAT_W-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             wbm_rty_i,
  output logic             reset_bq_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       err_code_o
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t           state, state_nxt;
  logic             bqsel, bqsel_nxt, both, both_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] rty_cnt, rty_nxt, tmo_cnt, tmo_nxt, rst_cnt, rst_nxt;
  logic             abort_pend, abort_nxt, acked, acked_nxt, rd_phase, rd_nxt;
  logic [2:0]       err_nxt, fail_code;
  logic             fail, idle_done, abort_any, verify_bad;
  logic             cyc_nxt, we_nxt, rstbq_nxt, busy_nxt, done_nxt;
  wb_req_t          req_q, req_nxt;
  logic [DAT_W-1:0] stg_word_c;

  biquad8_loader_stage_ram #(.NWORDS(NWORDS)) u_stage (
    .clk    (wb_clk_i),
    .we     (stg_we_i & ~busy_o),
    .wadr   (stg_adr_i),
    .wdat   (stg_dat_i),
    .radr   (idx_nxt),
    .rdat_c (stg_word_c)
  );

  assign abort_any = abort_pend | abort_i;

`ifdef BIQUAD8_LOADER_READBACK_EN
  // wbm_dat_o still holds the staged word during the verify read.
  assign verify_bad = (state == VERIFY) && (wbm_dat_i != req_q.dat);
`else
  logic unused_rd_dat;
  assign unused_rd_dat = ^wbm_dat_i;
  assign verify_bad    = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    bqsel_nxt = bqsel;
    both_nxt  = both;
    idx_nxt   = idx;
    rty_nxt   = rty_cnt;
    tmo_nxt   = tmo_cnt;
    rst_nxt   = rst_cnt;
    abort_nxt = abort_pend | (abort_i && (state != IDLE));
    acked_nxt = acked;
    rd_nxt    = rd_phase;
    err_nxt   = err_code_o;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    idle_done = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          err_nxt = ERR_NONE;
          if (target_i != 2'b00) begin
            state_nxt = ISSUE;
            both_nxt  = &target_i;
            bqsel_nxt = (target_i == 2'b10);
            idx_nxt   = '0;
            rty_nxt   = '0;
            tmo_nxt   = '0;
            abort_nxt = 1'b0;
            acked_nxt = 1'b0;
            rd_nxt    = 1'b0;
          end else begin
            idle_done = 1'b1;
          end
        end
      end
      ISSUE, VERIFY: begin
        if (wbm_err_i) begin
          fail      = 1'b1;
          fail_code = ERR_BUS;
        end else if (wbm_ack_i) begin
          if (verify_bad) begin
            fail      = 1'b1;
            fail_code = ERR_VERIFY;
          end else if (abort_any) begin
            fail      = 1'b1;
            fail_code = ERR_ABORT;
          end else begin
            state_nxt = GAP;
            rty_nxt   = '0;
`ifdef BIQUAD8_LOADER_READBACK_EN
            rd_nxt    = (state == ISSUE);
            acked_nxt = (state == VERIFY);
`else
            acked_nxt = 1'b1;
`endif
          end
        end else if (wbm_rty_i) begin
          if (32'(rty_cnt) + 32'd1 >= MAX_RTY) begin
            fail      = 1'b1;
            fail_code = ERR_RETRY;
          end else if (abort_any) begin
            fail      = 1'b1;
            fail_code = ERR_ABORT;
          end else begin
            state_nxt = GAP;
            rty_nxt   = rty_cnt + CNT_W'(1);
            acked_nxt = 1'b0;
          end
        end else if (32'(tmo_cnt) + 32'd1 >= TIMEOUT) begin
          fail      = 1'b1;
          fail_code = abort_any ? ERR_ABORT : ERR_TIMEOUT;
        end else begin
          tmo_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        tmo_nxt   = '0;
        acked_nxt = 1'b0;
        if (abort_any) begin
          fail      = 1'b1;
          fail_code = ERR_ABORT;
        end else if (rd_phase) begin
          state_nxt = VERIFY;
        end else if (!acked) begin
          state_nxt = ISSUE;
        end else if (idx != LAST_IDX) begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = ISSUE;
        end else if (both && !bqsel) begin
          bqsel_nxt = 1'b1;
          idx_nxt   = '0;
          state_nxt = ISSUE;
        end else begin
          rst_nxt   = '0;
          state_nxt = RSTQ;
        end
      end
      RSTQ: begin
        if (abort_any) begin
          fail      = 1'b1;
          fail_code = ERR_ABORT;
        end else if (32'(rst_cnt) + 32'd1 >= RST_CYCLES) begin
          state_nxt = DONE;
        end else begin
          rst_nxt = rst_cnt + CNT_W'(1);
        end
      end
      DONE, FAIL: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase

    if (fail) begin
      state_nxt = FAIL;
      err_nxt   = fail_code;
    end
  end

  // Next values of the registered outputs
  always_comb begin
    cyc_nxt   = (state_nxt == ISSUE) || (state_nxt == VERIFY);
    we_nxt    = (state_nxt == ISSUE);
    rstbq_nxt = (state_nxt == RSTQ);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE) || (state_nxt == FAIL) || idle_done;
    req_nxt   = '0;
    if (cyc_nxt) begin
      req_nxt.adr[IDX_W-1:0] = IDX_W'(32'(idx_nxt) * ADR_STEP);
      req_nxt.adr[BQSEL_BIT] = bqsel_nxt;
      req_nxt.dat            = stg_word_c;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      bqsel      <= 1'b0;
      both       <= 1'b0;
      idx        <= '0;
      rty_cnt    <= '0;
      tmo_cnt    <= '0;
      rst_cnt    <= '0;
      abort_pend <= 1'b0;
      acked      <= 1'b0;
      rd_phase   <= 1'b0;
      err_code_o <= ERR_NONE;
      wbm_cyc_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      req_q      <= '0;
      reset_bq_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bqsel      <= bqsel_nxt;
      both       <= both_nxt;
      idx        <= idx_nxt;
      rty_cnt    <= rty_nxt;
      tmo_cnt    <= tmo_nxt;
      rst_cnt    <= rst_nxt;
      abort_pend <= abort_nxt;
      acked      <= acked_nxt;
      rd_phase   <= rd_nxt;
      err_code_o <= err_nxt;
      wbm_cyc_o  <= cyc_nxt;
      wbm_we_o   <= we_nxt;
      req_q      <= req_nxt;
      reset_bq_o <= rstbq_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
    end
  end

  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_adr_o = req_q.adr;
  assign wbm_dat_o = req_q.dat;
  assign wbm_sel_o = 4'hF;

endmodule

// File: doc/biquad8_coeff_loader.md
Name: biquad8_coeff_loader

Overview:
- Wishbone master sequencer that bulk-loads a staged coefficient set into one or both biquads of the serial biquad pair (bq0 / bq1), then pulses the biquad datapath reset so the new coefficients start from clean state.
- Sits between the PS-side register space, which stages words and issues start, and the pair's 22-bit / 32-bit Wishbone target port. Address bit 7 selects bq1.
- Replaces word-by-word software loading. Reports busy, done and an error code.

Parameters:
- NWORDS, 32, coefficient words per biquad (1..128).
- ADR_STEP, 1, target address increment per word.
- TIMEOUT, 255, wb_clk_i cycles to wait for ack/err/rty before failing.
- MAX_RTY, 3, retries allowed per word on rty.
- RST_CYCLES, 4, length of the reset_bq_o pulse.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- stg_we_i  in  1  staging buffer write strobe.
- stg_adr_i  in  7  staging word index.
- stg_dat_i  in  32  staging word.
- start_i  in  1  single-cycle start pulse.
- target_i  in  2  01 = bq0, 10 = bq1, 11 = bq0 then bq1; sampled at start.
- abort_i  in  1  abort request.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  22  Wishbone address = {14'b0, bqsel, idx*ADR_STEP[6:0]}.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  Wishbone byte select (always 4'hF).
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ack.
- wbm_err_i  in  1  Wishbone error.
- wbm_rty_i  in  1  Wishbone retry.
- reset_bq_o  out  1  biquad datapath reset (drives reset_BQ_i).
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at sequence end.
- err_code_o  out  3  0 none, 1 bus err, 2 retries exhausted, 3 timeout, 4 abort, 5 verify mismatch; held until next start.

Behaviour:
- Reset values: all wbm_* outputs 0 (wbm_sel_o = 4'hF), reset_bq_o 0, busy_o 0, done_o 0, err_code_o 0. State = IDLE. Staging buffer contents are not reset.
- Staging buffer: NWORDS x 32 registers.
  - Writes are accepted only when busy_o = 0; writes while busy are silently dropped.
  - Indices >= NWORDS are ignored.
- IDLE:
  - Start condition: start_i = 1 and target_i != 00. On it, latch target, idx = 0, rty_cnt = 0, clear err_code_o, go to ISSUE, and set busy_o the next cycle.
  - start_i with target_i = 00: done_o pulses and err_code_o stays 0.
- ISSUE:
  - cyc = stb = we = 1; adr and dat come from the current bqsel/idx.
  - The timeout counter resets on entry.
  - ack: go to GAP.
  - err: go to FAIL with code 1.
  - rty: rty_cnt++. If rty_cnt has reached MAX_RTY, go to FAIL with code 2; otherwise go to GAP without advancing.
  - Counter reaches TIMEOUT: go to FAIL with code 3.
  - Priority when inputs coincide: err > ack > rty.
- GAP: one cycle with cyc = stb = 0.
  - After an ack: advance idx and clear rty_cnt.
  - When idx wraps past NWORDS-1: if target = 11 and bqsel = 0, set bqsel = 1, idx = 0 and go to ISSUE; otherwise go to RSTQ.
- Cycle count: with a zero-wait slave (ack in the first stb cycle), each word takes exactly 2 cycles.
- RSTQ: reset_bq_o = 1 for RST_CYCLES cycles, then go to DONE.
- DONE: done_o = 1 for one cycle, busy_o drops in the same cycle, return to IDLE.
- FAIL: cyc/stb deassert immediately; reset_bq_o is not pulsed; behave as DONE with err_code_o set.
- abort_i while busy:
  - In ISSUE, the current transfer completes or times out first, then go to FAIL with code 4.
  - In GAP or RSTQ, go to FAIL with code 4 on the next cycle. A reset_bq_o pulse already in progress is cut short.
- start_i while busy is ignored.
- wb_rst_i mid-transfer: all outputs return to reset values on the next edge, even with cyc asserted. The slave tolerates this because its own wb_rst_i is tied low.

Optional Feature:
- Macro BIQUAD8_LOADER_READBACK_EN.
- When defined: after each acked write, add a VERIFY read (we = 0, same address) followed by a GAP cycle. On ack, compare wbm_dat_i with the staged word; a mismatch goes to FAIL with code 5. Read err, rty and timeout are handled as for the write. Each word then takes 4 cycles with a zero-wait slave.
- When undefined: the VERIFY state is absent and wbm_dat_i is unused.

Decomposition:
- Package biquad8_loader_pkg:
  - state enum (IDLE, ISSUE, GAP, VERIFY, RSTQ, DONE, FAIL);
  - error-code localparams ERR_NONE..ERR_VERIFY;
  - BQSEL_BIT = 7.
- One sub-module, biquad8_loader_stage_ram: the staging buffer, with its write port plus a combinational read by index.

Test Plan:
1. Stage words 0x1000+i (i = 0..31), target 01, zero-wait slave:
   - 32 writes to addresses 0x000..0x01F;
   - busy_o for 64 + RST_CYCLES + 1 cycles;
   - reset_bq_o high for 4 cycles, done_o pulses, err_code_o = 0.
2. Target 11:
   - 64 writes, bq1 at addresses 0x080..0x09F with the same data;
   - exactly one reset_bq_o pulse, after the last write.
3. Slave rtys word 5 three times:
   - with MAX_RTY = 3, the FAIL error (code 2) is raised and no reset pulse occurs;
   - rty twice then ack: the sequence completes with code 0.
4. Silent slave:
   - timeout after 255 cycles, code 3, cyc drops the next cycle;
   - err on word 0 gives code 1.
5. abort_i at word 10, then start_i while busy:
   - the start is ignored;
   - code 4 follows the in-flight ack;
   - stg_we_i writes issued during busy do not alter the buffer.
6. With BIQUAD8_LOADER_READBACK_EN defined, the slave returns a corrupted word 7: code 5, and no writes are issued past word 7.
